// File: rtl/wlc_pkg.sv
// rtl/wlc_pkg.sv - shared state encoding and helpers for the tank fill scheduler
package wlc_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_COOL  = 3'd3;
  localparam logic [2:0] S_CLOSE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_OPEN  = S_OPEN,
    ST_FILL  = S_FILL,
    ST_COOL  = S_COOL,
    ST_CLOSE = S_CLOSE
  } state_t;

  // Bits needed to index n items; at least 1 so a two-tank build still has an index bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/tank_fill_scheduler_rr_arbiter.sv
// rtl/tank_fill_scheduler_rr_arbiter.sv - combinational round-robin pick among requesting tanks
module rr_arbiter
  import wlc_pkg::*;
#(
  parameter int NT = 3,
  parameter int GW = clog2(NT)
) (
  input  logic [NT-1:0] req,
  input  logic [GW-1:0] rr_ptr,
  output logic [NT-1:0] grant,
  output logic [GW-1:0] grant_idx,
  output logic          valid
);

  // Index k places after the pointer, wrapped into 0..NT-1.
  function automatic logic [GW-1:0] rot(input logic [GW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NT) s = s - NT;
    return GW'(s);
  endfunction

  logic [GW-1:0] idx;

  // Walk from the pointer upward; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NT; k++) begin
      idx = rot(rr_ptr, k);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tank_fill_scheduler.sv
// rtl/tank_fill_scheduler.sv - shares one supply pump between NT tanks, one grant at a time
module tank_fill_scheduler
  import wlc_pkg::*;
#(
  parameter int NT       = 3,
  parameter int SETTLE   = 4,
  parameter int MAX_FILL = 64,
  parameter int COOL     = 8,
  parameter int CW       = 8,
  localparam int GW      = clog2(NT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [NT-1:0] lvl_low,
  input  logic [NT-1:0] lvl_high,
  input  logic [NT-1:0] fault_clr,
  output logic [NT-1:0] valve,
  output logic          pump_on,
  output logic          busy,
  output logic [GW-1:0] grant_idx,
  output logic [NT-1:0] fault
);

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] FILL_END   = CW'(MAX_FILL - 1);
  localparam logic [CW-1:0] COOL_END   = CW'(COOL - 1);

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] timer;
  logic [CW-1:0] timer_inc;
  logic [NT-1:0] req;
  logic [NT-1:0] win_onehot;
  logic [GW-1:0] win_idx;
  logic          win_valid;
  logic [NT-1:0] fault_set;

  // A tank asks for water only when below low, not reading full, and not faulted;
  // a high reading without low (broken sensor pair) is treated as full.
  assign req = ~lvl_low & ~lvl_high & ~fault;

  // Timer sticks at all-ones rather than wrapping back into a valid compare value.
  assign timer_inc = (timer == {CW{1'b1}}) ? timer : timer + CW'(1);

  rr_arbiter #(
    .NT (NT),
    .GW (GW)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] i);
    if (i == GW'(NT - 1)) return '0;
    return i + GW'(1);
  endfunction

  // Timeout fault: pump time ran out without the granted tank reading full.
  always_comb begin
    fault_set = '0;
    if (state == ST_FILL && !lvl_high[grant_idx] && timer == FILL_END)
      fault_set[grant_idx] = 1'b1;
  end

  // Sticky faults; a new fault beats a clear arriving on the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault <= '0;
    else        fault <= (fault & ~fault_clr) | fault_set;
  end

  // Grant sequence: open valve, settle, pump, cool down, close valve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      valve     <= '0;
      pump_on   <= 1'b0;
      busy      <= 1'b0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && win_valid) begin
            state     <= ST_OPEN;
            busy      <= 1'b1;
            grant_idx <= win_idx;
            valve     <= win_onehot;
            rr_ptr    <= ptr_after(win_idx);
            timer     <= '0;
          end
        end
        ST_OPEN: begin
          if (!en) begin
            state <= ST_CLOSE;
            timer <= '0;
          end else if (timer == SETTLE_END) begin
            state   <= ST_FILL;
            pump_on <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_FILL: begin
          if (lvl_high[grant_idx] || timer == FILL_END || !en) begin
            state   <= ST_COOL;
            pump_on <= 1'b0;
            timer   <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_COOL: begin
          if (timer == COOL_END) begin
            state <= ST_CLOSE;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_CLOSE: begin
          state <= ST_IDLE;
          valve <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          valve   <= '0;
          pump_on <= 1'b0;
          busy    <= 1'b0;
          timer   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tank_fill_scheduler.sv
// tb/tb_tank_fill_scheduler.sv - directed and randomized checks of tank_fill_scheduler against a behavioural model
module tb_tank_fill_scheduler;

  localparam int NT       = 3;
  localparam int SETTLE   = 4;
  localparam int MAX_FILL = 64;
  localparam int COOL_N   = 8;

  localparam int W_VALVE_NZ = 0;
  localparam int W_VALVE_Z  = 1;
  localparam int W_PUMP_HI  = 2;
  localparam int W_PUMP_LO  = 3;

  localparam int P_WAIT  = 0;
  localparam int P_SETTL = 1;
  localparam int P_PUMP  = 2;
  localparam int P_COOL  = 3;
  localparam int P_SHUT  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [NT-1:0] lvl_low = '1;
  logic [NT-1:0] lvl_high = '1;
  logic [NT-1:0] fault_clr = '0;
  logic [NT-1:0] valve;
  logic          pump_on;
  logic          busy;
  logic [1:0]    grant_idx;
  logic [NT-1:0] fault;

  int tests = 0;
  int fails = 0;
  bit pump_seen = 0;

  int            m_phase = P_WAIT;
  int            m_cnt = 0;
  int            m_ptr = 0;
  int            m_grant = 0;
  logic [NT-1:0] m_valve = '0;
  bit            m_pump = 0;
  logic [NT-1:0] m_fault = '0;

  tank_fill_scheduler #(
    .NT(NT), .SETTLE(SETTLE), .MAX_FILL(MAX_FILL), .COOL(COOL_N), .CW(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .lvl_low(lvl_low), .lvl_high(lvl_high),
    .fault_clr(fault_clr), .valve(valve), .pump_on(pump_on), .busy(busy),
    .grant_idx(grant_idx), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one grant is a session of valve-open time, pump time and cooldown.
  task automatic model_step();
    int ph, cnt, ptr, g, w;
    logic [NT-1:0] v, f;
    bit p;
    ph = m_phase; cnt = m_cnt; ptr = m_ptr; g = m_grant; v = m_valve; p = m_pump;
    f = m_fault & ~fault_clr;
    case (ph)
      P_WAIT: if (en) begin
        w = -1;
        for (int k = 0; k < NT; k++) begin
          int t;
          t = (ptr + k) % NT;
          if (w < 0 && !lvl_low[t] && !lvl_high[t] && !m_fault[t]) w = t;
        end
        if (w >= 0) begin
          g = w; v = '0; v[w] = 1'b1; ptr = (w + 1) % NT; ph = P_SETTL; cnt = 0;
        end
      end
      P_SETTL: begin
        cnt++;
        if (!en) ph = P_SHUT;
        else if (cnt == SETTLE) begin ph = P_PUMP; p = 1; cnt = 0; end
      end
      P_PUMP: begin
        cnt++;
        if (lvl_high[g] || cnt == MAX_FILL || !en) begin
          if (!lvl_high[g] && cnt == MAX_FILL) f[g] = 1'b1;
          ph = P_COOL; p = 0; cnt = 0;
        end
      end
      P_COOL: begin
        cnt++;
        if (cnt == COOL_N) ph = P_SHUT;
      end
      default: begin v = '0; ph = P_WAIT; end
    endcase
    m_phase <= ph; m_cnt <= cnt; m_ptr <= ptr; m_grant <= g;
    m_valve <= v; m_pump <= p; m_fault <= f;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_WAIT; m_cnt <= 0; m_ptr <= 0; m_grant <= 0;
      m_valve <= '0; m_pump <= 0; m_fault <= '0;
    end else begin
      model_step();
    end
  end

  // Every cycle: DUT against the model, plus the valve/pump safety invariants.
  always @(negedge clk) begin
    check("valve", valve, m_valve);
    check("pump_on", pump_on, m_pump);
    check("busy", busy, m_phase != P_WAIT);
    check("grant_idx", grant_idx, m_grant);
    check("fault", fault, m_fault);
    check("inv_valve_le1hot", $countones(valve) <= 1, 1);
    if (pump_on) check("inv_pump_onehot", $countones(valve), 1);
    pump_seen = pump_seen | pump_on;
  end

  task automatic wait_cond(input int which, input int budget, input string name, output int n);
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        W_VALVE_NZ: hit = (valve != '0);
        W_VALVE_Z:  hit = (valve == '0);
        W_PUMP_HI:  hit = pump_on;
        default:    hit = !pump_on;
      endcase
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s actual=no event required=event within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    en = 1'b0; fault_clr = '0; lvl_low = '1; lvl_high = '1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int n;
  int lev [NT];
  int rate [NT];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    check("rst_valve", valve, 0);
    check("rst_pump", pump_on, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_fault", fault, 0);
    reset = 1'b1;

    // Single request on tank 1
    do_reset();
    lvl_low = 3'b101; lvl_high = 3'b101; en = 1'b1;
    wait_cond(W_VALVE_NZ, 20, "t1_grant", n);
    check("t1_valve", valve, 3'b010);
    wait_cond(W_PUMP_HI, 20, "t1_pump_wait", n);
    check("t1_settle", n, 4);
    repeat (10) @(negedge clk);
    lvl_high[1] = 1'b1; lvl_low[1] = 1'b1;
    @(negedge clk);
    check("t1_pump_off", pump_on, 0);
    wait_cond(W_VALVE_Z, 30, "t1_close_wait", n);
    check("t1_cool", n, 9);
    check("t1_fault", fault, 0);

    // Round-robin with all tanks asking
    do_reset();
    lvl_low = '0; lvl_high = '0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cond(W_PUMP_HI, 40, "t2_pump_wait", n);
      check("t2_rr_idx", grant_idx, k % NT);
      check("t2_rr_valve", valve, 3'b001 << (k % NT));
      repeat (3) @(negedge clk);
      lvl_high[k % NT] = 1'b1;
      @(negedge clk);
      check("t2_pump_off", pump_on, 0);
      lvl_high[k % NT] = 1'b0;
    end
    lvl_low = '1; lvl_high = '1;
    wait_cond(W_VALVE_Z, 30, "t2_close_wait", n);

    // Timeout on tank 2, then clear and regrant
    do_reset();
    lvl_low = 3'b011; lvl_high = 3'b011; en = 1'b1;
    wait_cond(W_PUMP_HI, 20, "t3_pump_wait", n);
    wait_cond(W_PUMP_LO, 100, "t3_pump_drop", n);
    check("t3_pump_len", n, 64);
    check("t3_fault", fault, 3'b100);
    wait_cond(W_VALVE_Z, 30, "t3_close_wait", n);
    repeat (30) @(negedge clk);
    check("t3_no_regrant", busy, 0);
    fault_clr = 3'b100;
    @(negedge clk);
    fault_clr = '0;
    check("t3_cleared", fault, 0);
    wait_cond(W_VALVE_NZ, 20, "t3_regrant", n);
    check("t3_regrant_valve", valve, 3'b100);
    wait_cond(W_PUMP_HI, 20, "t3_pump2", n);
    lvl_low = '1; lvl_high = '1;
    wait_cond(W_VALVE_Z, 30, "t3_close2", n);

    // Full reading on the timeout cycle, then fault set racing a clear
    do_reset();
    lvl_low = 3'b110; lvl_high = 3'b110; en = 1'b1;
    wait_cond(W_PUMP_HI, 20, "t4_pump_wait", n);
    repeat (63) @(negedge clk);
    lvl_high[0] = 1'b1;
    @(negedge clk);
    check("t4_tie_pump", pump_on, 0);
    check("t4_tie_no_fault", fault, 0);
    lvl_high[0] = 1'b0;
    wait_cond(W_PUMP_HI, 40, "t4_pump2", n);
    repeat (63) @(negedge clk);
    fault_clr = 3'b001;
    @(negedge clk);
    fault_clr = '0;
    check("t4_set_wins", fault, 3'b001);
    lvl_low = '1; lvl_high = '1;
    wait_cond(W_VALVE_Z, 30, "t4_close", n);
    fault_clr = 3'b001;
    @(negedge clk);
    fault_clr = '0;

    // Enable drop during pumping and during settling
    do_reset();
    lvl_low = 3'b101; lvl_high = 3'b101; en = 1'b1;
    wait_cond(W_PUMP_HI, 20, "t5_pump_wait", n);
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("t5_pump_drop", pump_on, 0);
    wait_cond(W_VALVE_Z, 30, "t5_close_wait", n);
    check("t5_cool", n, 9);
    check("t5_busy", busy, 0);
    pump_seen = 0;
    en = 1'b1;
    wait_cond(W_VALVE_NZ, 20, "t5_regrant", n);
    @(negedge clk);
    en = 1'b0;
    wait_cond(W_VALVE_Z, 10, "t5_open_close", n);
    check("t5_open_close_lat", n, 2);
    check("t5_no_pump", pump_seen, 0);

    // Asynchronous reset in the middle of pumping
    do_reset();
    lvl_low = 3'b011; lvl_high = 3'b011; en = 1'b1;
    wait_cond(W_PUMP_HI, 20, "t6_pump_wait", n);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_valve", valve, 0);
    check("t6_pump", pump_on, 0);
    check("t6_busy", busy, 0);
    check("t6_fault", fault, 0);
    @(negedge clk);
    lvl_low = '0; lvl_high = '0;
    reset = 1'b1;
    wait_cond(W_VALVE_NZ, 20, "t6_first_grant", n);
    check("t6_first_valve", valve, 3'b001);
    lvl_low = '1; lvl_high = '1;
    wait_cond(W_VALVE_Z, 40, "t6_close", n);

    // Randomized plant: tanks fill at a per-tank rate while pumped and drain slowly otherwise
    do_reset();
    for (int i = 0; i < NT; i++) begin lev[i] = 0; rate[i] = $urandom_range(0, 3); end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 500 == 499)
        for (int i = 0; i < NT; i++) rate[i] = $urandom_range(0, 3);
      for (int i = 0; i < NT; i++) begin
        if (pump_on && valve[i]) lev[i] = (lev[i] + rate[i] > 20) ? 20 : lev[i] + rate[i];
        else if ($urandom_range(0, 5) == 0 && lev[i] > 0) lev[i] = lev[i] - 1;
        lvl_low[i]   = (lev[i] >= 4);
        lvl_high[i]  = (lev[i] >= 12);
        if ($urandom_range(0, 49) == 0) begin lvl_high[i] = 1'b1; lvl_low[i] = 1'b0; end
        fault_clr[i] = ($urandom_range(0, 63) == 0);
      end
      en = ($urandom_range(0, 19) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
